// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register.
// Responses that cannot enter IF/ID park in a hold buffer; redirected requests are drained.
module if_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [9:0]  branch_address,
  input  logic        jump,
  input  logic [9:0]  jump_address,
  input  logic        Data_Hazard,
  input  logic        IF_Flush,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [9:0]  if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] pc_plus4;
    logic [DW-1:0] instr;
    logic          valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{pc_plus4: '0, instr: '0, valid: 1'b0};

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_drain;
  ifid_t         r_hold;
  ifid_t         r_ifid;
  logic          r_active;

  state_t        w_state;
  logic [AW-1:0] w_pc;
  logic [AW-1:0] w_drain;
  ifid_t         w_hold;
  ifid_t         w_ifid;

  logic          w_redirect;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_pc_plus4;
  logic          w_req;
  logic          w_ready;
  logic          w_advance;

  // Request decode; r_active keeps imem_req low until the cycle after reset releases.
  always_comb begin
    w_req     = r_active && (r_state != S_HOLD);
    imem_req  = w_req;
    imem_addr = (r_state == S_DRAIN) ? r_drain : r_pc;
  end

  assign w_redirect = jump | branch_taken;
  assign w_target   = jump ? {jump_address[AW-1:2], 2'b00} : {branch_address[AW-1:2], 2'b00};
  assign w_pc_plus4 = r_pc + AW'(4);
  assign w_ready    = imem_ready & w_req;
  assign w_advance  = Data_Hazard & ~IF_Flush;

  // Next-state, pc, hold buffer and IF/ID selection.
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_drain = r_drain;
    w_hold  = r_hold;
    w_ifid  = Data_Hazard ? BUBBLE : r_ifid;

    case (r_state)
      S_FETCH: begin
        if (w_redirect) begin
          w_pc = w_target;
          if (w_req && !w_ready) begin
            w_drain = r_pc;
            w_state = S_DRAIN;
          end
        end else if (w_ready) begin
          w_pc = w_pc_plus4;
          if (w_advance) begin
            w_ifid = '{pc_plus4: w_pc_plus4, instr: imem_rdata, valid: 1'b1};
          end else begin
            w_hold  = '{pc_plus4: w_pc_plus4, instr: imem_rdata, valid: 1'b1};
            w_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc    = w_target;
          w_hold  = BUBBLE;
          w_state = S_FETCH;
        end else if (w_advance) begin
          w_ifid  = r_hold;
          w_hold  = BUBBLE;
          w_state = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_redirect) begin
          w_pc = w_target;
        end
        if (w_ready) begin
          w_state = S_FETCH;
        end
      end
      default: begin
        w_state = S_FETCH;
      end
    endcase

    // Redirect and flush always squash IF/ID, whatever the stall state.
    if (w_redirect || IF_Flush) begin
      w_ifid = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_drain  <= '0;
      r_hold   <= BUBBLE;
      r_ifid   <= BUBBLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_drain  <= w_drain;
      r_hold   <= w_hold;
      r_ifid   <= w_ifid;
      r_active <= 1'b1;
    end
  end

  assign if_id_pc_plus4 = r_ifid.pc_plus4;
  assign if_id_instr    = r_ifid.instr;
  assign if_id_valid    = r_ifid.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Cycle-vector bench for if_fetch_unit: each record drives one cycle and states the
// expected request seen that cycle and the IF/ID contents after the edge.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [9:0]  branch_address;
  logic        jump;
  logic [9:0]  jump_address;
  logic        Data_Hazard;
  logic        IF_Flush;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [9:0]  if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .Data_Hazard    (Data_Hazard),
    .IF_Flush       (IF_Flush),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       br;
    logic [9:0] baddr;
    logic       jmp;
    logic [9:0] jaddr;
    logic       dh;
    logic       fl;
    logic       rdy;
    logic       e_req;
    logic [9:0] e_addr;
    logic       e_valid;
    logic [9:0] e_pc4;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  // Address-tagged instruction words; anything outside a ready cycle is garbage.
  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {16'hC0DE, 6'h00, a};
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  function automatic vec_t mk(input int rst, input int br, input int baddr, input int jmp,
                              input int jaddr, input int dh, input int fl, input int rdy,
                              input int ereq, input int eaddr, input int evalid, input int epc4);
    vec_t v;
    v.rst = 1'(rst);     v.br = 1'(br);       v.baddr = 10'(baddr);
    v.jmp = 1'(jmp);     v.jaddr = 10'(jaddr); v.dh = 1'(dh);
    v.fl = 1'(fl);       v.rdy = 1'(rdy);     v.e_req = 1'(ereq);
    v.e_addr = 10'(eaddr); v.e_valid = 1'(evalid); v.e_pc4 = 10'(epc4);
    return v;
  endfunction

  task automatic step(input int idx, input vec_t v);
    vec_t        e;
    logic [31:0] e_instr;
    logic [9:0]  e_pc4;
    @(negedge clk);
    reset = v.rst; branch_taken = v.br; branch_address = v.baddr;
    jump = v.jmp; jump_address = v.jaddr; Data_Hazard = v.dh;
    IF_Flush = v.fl; imem_ready = v.rdy;
    exp_q.push_back(v);
    #1;
    n_cmp++;
    if (imem_req !== v.e_req || (v.e_req && imem_addr !== v.e_addr)) begin
      n_err++;
      $display("FAIL req[%0d]: got req=%b addr=%h, want req=%b addr=%h",
               idx, imem_req, imem_addr, v.e_req, v.e_addr);
    end
    @(posedge clk);
    #1;
    e       = exp_q.pop_front();
    e_pc4   = e.e_valid ? e.e_pc4 : 10'h000;
    e_instr = e.e_valid ? mem_word(10'(e.e_pc4 - 10'd4)) : 32'h0;
    n_cmp++;
    if (if_id_valid !== e.e_valid || if_id_pc_plus4 !== e_pc4 || if_id_instr !== e_instr) begin
      n_err++;
      $display("FAIL ifid[%0d]: got v=%b pc4=%h ins=%h, want v=%b pc4=%h ins=%h",
               idx, if_id_valid, if_id_pc_plus4, if_id_instr, e.e_valid, e_pc4, e_instr);
    end
  endtask

  initial begin
    reset = 1'b0; branch_taken = 1'b0; branch_address = '0; jump = 1'b0;
    jump_address = '0; Data_Hazard = 1'b1; IF_Flush = 1'b0; imem_ready = 1'b0;

    //          rst br baddr  jmp jaddr  dh fl rdy  req addr   val pc4
    // reset, then zero-wait stream A,B,C
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 0, 0,   0, 0,      0, 0));
    vecs.push_back(mk(0, 0, 0,     0, 0,     1, 0, 0,   0, 0,      0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   0, 0,      0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h000,  1, 'h004));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h004,  1, 'h008));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h008,  1, 'h00C));
    // stall while the next word returns: parked in HOLD, no request
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 1,   1, 'h00C,  1, 'h00C));
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0,   0, 0,      1, 'h00C));
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0,   0, 0,      1, 'h00C));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   0, 0,      1, 'h010));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h010,  1, 'h014));
    // slow memory, branch while request outstanding -> drain
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   1, 'h014,  0, 0));
    vecs.push_back(mk(1, 1, 'h040, 0, 0,     1, 0, 0,   1, 'h014,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h014,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   1, 'h040,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h040,  1, 'h044));
    // jump beats branch, returned word dropped
    vecs.push_back(mk(1, 1, 'h080, 1, 'h100, 1, 0, 1,   1, 'h044,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h100,  1, 'h104));
    // flush with data returning: bubble, word kept in HOLD
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 1, 1,   1, 'h104,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   0, 0,      1, 'h108));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h108,  1, 'h10C));
    // redirect out of HOLD under stall, then wrap at 0x3FC
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 1,   1, 'h10C,  1, 'h10C));
    vecs.push_back(mk(1, 1, 'h3F8, 0, 0,     0, 0, 0,   0, 0,      0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h3F8,  1, 'h3FC));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h3FC,  1, 'h000));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 0,   1, 'h000,  0, 0));
    // second redirect inside DRAIN only moves pc
    vecs.push_back(mk(1, 0, 0,     1, 'h200, 1, 0, 0,   1, 'h000,  0, 0));
    vecs.push_back(mk(1, 1, 'h2F0, 0, 0,     1, 0, 0,   1, 'h000,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h000,  0, 0));
    vecs.push_back(mk(1, 0, 0,     0, 0,     1, 0, 1,   1, 'h2F0,  1, 'h2F4));
    vecs.push_back(mk(1, 0, 0,     0, 0,     0, 0, 0,   1, 'h2F4,  1, 'h2F4));

    for (int i = 0; i < vecs.size(); i++) begin
      step(i, vecs[i]);
    end

    // reset asserted mid-DRAIN
    step(100, mk(1, 0, 0, 1, 'h080, 1, 0, 0,   1, 'h2F4, 0, 0));
    step(101, mk(0, 0, 0, 0, 0,     1, 0, 0,   1, 'h2F4, 0, 0));
    step(102, mk(1, 0, 0, 0, 0,     1, 0, 0,   0, 0,     0, 0));
    step(103, mk(1, 0, 0, 0, 0,     1, 0, 1,   1, 'h000, 1, 'h004));
    // flush under stall with no data still bubbles
    step(104, mk(1, 0, 0, 0, 0,     0, 1, 0,   1, 'h004, 0, 0));
    step(105, mk(1, 0, 0, 0, 0,     1, 0, 1,   1, 'h004, 1, 'h008));

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-003 branch_taken  input  1  decode stage resolved a taken branch this cycle.
REQ-004 branch_address  input  10  byte address of the branch target.
REQ-005 jump  input  1  decode stage holds a jump this cycle.
REQ-006 jump_address  input  10  byte address of the jump target.
REQ-007 Data_Hazard  input  1  high = decode may advance; low = decode stalled, IF/ID holds.
REQ-008 IF_Flush  input  1  high = load a bubble into IF/ID this cycle.
REQ-009 imem_req  output  1  instruction memory request valid.
REQ-010 imem_addr  output  10  byte address of the request; bits [1:0] always 0.
REQ-011 imem_ready  input  1  memory returns imem_rdata this cycle for the outstanding request.
REQ-012 imem_rdata  input  32  instruction word; valid only when imem_ready=1.
REQ-013 if_id_pc_plus4  output  10  IF/ID register: fetched PC + 4.
REQ-014 if_id_instr  output  32  IF/ID register: instruction word; 32'h0 = bubble.
REQ-015 if_id_valid  output  1  IF/ID register holds a real instruction.

Function
REQ-016 Memory protocol SHALL be one outstanding request; imem_req and imem_addr held stable from assertion until the cycle imem_ready=1.
REQ-017 Internal registers SHALL be: pc (10 bit), hold buffer (instr + pc_plus4), drain address, FSM state in {FETCH, HOLD, DRAIN}.
REQ-018 pc+4 arithmetic SHALL be 10-bit modulo; 10'h3FC + 4 = 10'h000.
REQ-019 Redirect = jump | branch_taken; target = jump_address when jump=1, else branch_address (jump has priority).
REQ-020 Event priority each cycle SHALL be: reset > redirect > IF_Flush > Data_Hazard stall.
REQ-021 FETCH: imem_req=1, imem_addr=pc.
REQ-022 FETCH, imem_ready=1, no redirect, no flush, Data_Hazard=1: IF/ID <= {pc+4, imem_rdata, valid=1}; pc <= pc+4; stay FETCH (back-to-back requests, one instruction per cycle).
REQ-023 FETCH, imem_ready=1, no redirect, and (Data_Hazard=0 or IF_Flush=1): data captured into hold buffer; pc <= pc+4; go HOLD.
REQ-024 FETCH, imem_ready=0, no redirect: pc unchanged; stay FETCH.
REQ-025 FETCH, redirect, imem_ready=1: returned data discarded; pc <= target; stay FETCH.
REQ-026 FETCH, redirect, imem_ready=0: drain address <= pc; pc <= target; go DRAIN.
REQ-027 HOLD: imem_req=0; Data_Hazard=1 and IF_Flush=0 and no redirect -> IF/ID <= hold buffer (valid=1), go FETCH; otherwise remain HOLD.
REQ-028 HOLD, redirect: hold buffer discarded; pc <= target; go FETCH.
REQ-029 DRAIN: imem_req=1, imem_addr=drain address; on imem_ready=1 data discarded, go FETCH; a further redirect in DRAIN updates pc only.
REQ-030 IF/ID load rule: redirect or IF_Flush -> IF/ID <= bubble (instr=32'h0, pc_plus4=0, valid=0), regardless of Data_Hazard.
REQ-031 Data_Hazard=1 with no instruction delivered (FETCH no ready, DRAIN, HOLD blocked) -> IF/ID <= bubble; no instruction SHALL ever be presented twice or skipped.
REQ-032 Data_Hazard=0, no flush, no redirect -> IF/ID holds its value.
REQ-033 All outputs SHALL be registered or decoded from registered state only (no input-to-output combinational path except none).

Reset
REQ-034 reset=0 at an edge SHALL set pc=0, state=FETCH, IF/ID = bubble (0, 0, valid=0), hold buffer cleared, regardless of outstanding request.
REQ-035 While reset=0, imem_req SHALL be 0; first request (addr 0) issued the cycle after reset deasserts; memory shall be reset with the block.

Verification
REQ-036 Zero-wait memory, Data_Hazard=1: instrs A,B,C at 0,4,8 -> IF/ID shows (4,A),(8,B),(12,C) on consecutive cycles, valid=1.
REQ-037 Data_Hazard=0 for 3 cycles while B returns -> IF/ID holds (4,A); B in HOLD, imem_req=0; Data_Hazard=1 -> (8,B) next cycle, fetch resumes at 8.
REQ-038 2-cycle-latency memory, branch_taken with branch_address=10'h040 one cycle after request to 8 -> req at 8 held until ready, data dropped, next req at 0x040, IF/ID bubble meanwhile.
REQ-039 jump=1 and branch_taken=1 same cycle, jump_address=0x100, branch_address=0x080 -> next fetch at 0x100.
REQ-040 pc=0x3FC fetch -> if_id_pc_plus4=0x000, next imem_addr=0x000.
REQ-041 reset=0 mid-DRAIN -> next cycle pc=0, IF/ID bubble, imem_req=0; reset=1 -> request at 0.
